wish_unpack: RTL

//  Splits one wide Wishbone word into NUM_PACK narrow beats; the inverse of wish_pack.

---
 rtl/wish_pkg.sv | 19 +
 rtl/wish_hold_buf.sv | 33 +++
 rtl/wish_unpack.sv | 116 +++++++++++
 3 files changed

// File: rtl/wish_pkg.sv
// Shared helpers for the wish_pack / wish_unpack width converters.
package wish_pkg;

  // Width of a beat index; never below 1 bit so NUM_PACK=2 still gets a register.
  function automatic int idx_width(input int num_pack);
    return (num_pack <= 2) ? 1 : $clog2(num_pack);
  endfunction

  // Index of the first beat of a word for the given byte order.
  function automatic int first_idx(input int little_endian, input int num_pack);
    return (little_endian != 0) ? 0 : num_pack - 1;
  endfunction

  // Index of the last beat of a word for the given byte order.
  function automatic int last_idx(input int little_endian, input int num_pack);
    return (little_endian != 0) ? num_pack - 1 : 0;
  endfunction

endpackage

// File: rtl/wish_hold_buf.sv
// One-entry holding register (valid + payload); full mirrors the valid bit.
module wish_hold_buf #(
  parameter int W = 34
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  logic         vld_reg;
  logic [W-1:0] dat_reg;

  // Push wins over pop so a refill in the same cycle keeps the entry valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_reg <= 1'b0;
      dat_reg <= '0;
    end else if (push) begin
      vld_reg <= 1'b1;
      dat_reg <= din;
    end else if (pop) begin
      vld_reg <= 1'b0;
    end
  end

  assign dout = dat_reg;
  assign full = vld_reg;

endmodule

// File: rtl/wish_unpack.sv
// Wide-to-narrow Wishbone converter: one wide word leaves as NUM_PACK beats.
module wish_unpack
  import wish_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_PACK      = 4,
  parameter int TGC_WIDTH     = 2,
  parameter int LITTLE_ENDIAN = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           s_stb_i,
  input  logic                           s_cyc_i,
  output logic                           s_ack_o,
  output logic                           s_stall_o,
  input  logic [DATA_WIDTH*NUM_PACK-1:0] s_dat_i,
  input  logic [TGC_WIDTH-1:0]           s_tgc_i,
  output logic                           d_stb_o,
  output logic                           d_cyc_o,
  input  logic                           d_ack_i,
  output logic [DATA_WIDTH-1:0]          d_dat_o,
  output logic [TGC_WIDTH-1:0]           d_tgc_o
);

  localparam int WIDE_W = DATA_WIDTH * NUM_PACK;
  localparam int HOLD_W = WIDE_W + TGC_WIDTH;
  localparam int IDX_W  = idx_width(NUM_PACK);
  localparam logic [IDX_W-1:0] START = IDX_W'(first_idx(LITTLE_ENDIAN, NUM_PACK));
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(last_idx(LITTLE_ENDIAN, NUM_PACK));

  logic                  hold_vld;
  logic [HOLD_W-1:0]     hold_dat;
  logic                  act_vld_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [WIDE_W-1:0]     data_reg;
  logic [TGC_WIDTH-1:0]  tgc_reg;
  logic [DATA_WIDTH-1:0] beat [NUM_PACK];

  logic accept;
  logic xfer;
  logic last_xfer;
  logic stage_free;
  logic load_hold;
  logic load_in;
  logic push;

  // Handshake decode: the shift stage frees up when empty or on its last beat.
  always_comb begin
    accept     = s_stb_i & s_cyc_i & ~hold_vld & ~rst_i;
    xfer       = act_vld_reg & d_ack_i;
    last_xfer  = xfer & (idx_reg == LAST);
    stage_free = ~act_vld_reg | last_xfer;
    load_hold  = hold_vld & stage_free;
    // With the hold buffer empty, a fresh word bypasses it straight into the
    // shift stage, so the first beat shows up the cycle after the accept.
    load_in    = accept & stage_free;
    push       = accept & ~stage_free;
  end

  wish_hold_buf #(
    .W (HOLD_W)
  ) u_hold (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push),
    .pop   (load_hold),
    .din   ({s_tgc_i, s_dat_i}),
    .dout  (hold_dat),
    .full  (hold_vld)
  );

  // Shift stage and beat index: load a word, step through beats, retire on last.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      act_vld_reg <= 1'b0;
      idx_reg     <= START;
      data_reg    <= '0;
      tgc_reg     <= '0;
    end else if (load_hold) begin
      act_vld_reg <= 1'b1;
      idx_reg     <= START;
      data_reg    <= hold_dat[WIDE_W-1:0];
      tgc_reg     <= hold_dat[HOLD_W-1:WIDE_W];
    end else if (load_in) begin
      act_vld_reg <= 1'b1;
      idx_reg     <= START;
      data_reg    <= s_dat_i;
      tgc_reg     <= s_tgc_i;
    end else if (last_xfer) begin
      act_vld_reg <= 1'b0;
      idx_reg     <= START;
    end else if (xfer) begin
      if (LITTLE_ENDIAN != 0) begin
        idx_reg <= idx_reg + IDX_W'(1);
      end else begin
        idx_reg <= idx_reg - IDX_W'(1);
      end
    end
  end

  // Split the wide word into beat-sized slices once; the index picks one.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PACK; gi++) begin : g_beat
      assign beat[gi] = data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  assign s_ack_o   = accept;
  assign s_stall_o = hold_vld;
  assign d_stb_o   = act_vld_reg;
  assign d_cyc_o   = act_vld_reg;
  assign d_dat_o   = beat[idx_reg];
  assign d_tgc_o   = tgc_reg;

endmodule
